// File: rtl/ddr_arb_pkg.sv
// Shared types, default widths and packed-vector helpers for the DDR burst arbiter.
package ddr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } arb_state_t;

  localparam int DEF_NUM_CH     = 3;
  localparam int DEF_ADDR_WIDTH = 28;
  localparam int DEF_DATA_WIDTH = 128;
  localparam int DEF_LEN_WIDTH  = 10;

  localparam int FIELD_MAX = 256;
  localparam int VEC_MAX   = 2048;

  // Extracts field idx of the given width from a packed per-channel vector.
  function automatic logic [FIELD_MAX-1:0] unpack_field(input logic [VEC_MAX-1:0] vec,
                                                        input int idx, input int width);
    logic [FIELD_MAX-1:0] mask;
    mask = (FIELD_MAX'(1) << width) - FIELD_MAX'(1);
    return FIELD_MAX'(vec >> (idx * width)) & mask;
  endfunction

  function automatic int onehot_index(input logic [63:0] onehot);
    int idx;
    idx = 0;
    for (int i = 0; i < 64; i++) begin
      if (onehot[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority picker: the search starts at ptr and wraps.
module rr_arbiter #(
  parameter int NUM_CH = 3,
  parameter int PTR_W  = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  output logic [NUM_CH-1:0] grant
);

  logic [NUM_CH-1:0] rot;
  logic [NUM_CH-1:0] rot_pick;

  // Rotate so ptr lands at bit 0, isolate the lowest set bit, rotate back.
  assign rot      = NUM_CH'({req, req} >> ptr);
  assign rot_pick = rot & (-rot);
  assign grant    = NUM_CH'(({rot_pick, rot_pick} << ptr) >> NUM_CH);

endmodule

// File: rtl/ddr_burst_arbiter.sv
// Multi-channel DDR burst arbiter: grants one channel a whole read or write burst.
// state | meaning: IDLE arbitrate | RD read burst open | WR write burst open | DONE ch_done pulse
module ddr_burst_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int NUM_CH         = DEF_NUM_CH,
  parameter int DDR_ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DDR_DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH      = DEF_LEN_WIDTH,
  parameter int RR_EN          = 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_CH-1:0]                  ch_rd_req,
  input  logic [NUM_CH-1:0]                  ch_wr_req,
  input  logic [NUM_CH*LEN_WIDTH-1:0]        ch_len,
  input  logic [NUM_CH*DDR_ADDR_WIDTH-1:0]   ch_addr,
  input  logic [NUM_CH*DDR_DATA_WIDTH-1:0]   ch_wr_data,
  output logic [NUM_CH-1:0]                  ch_grant,
  output logic [NUM_CH-1:0]                  ch_rd_valid,
  output logic [NUM_CH-1:0]                  ch_wr_data_req,
  output logic [NUM_CH-1:0]                  ch_done,
  output logic [DDR_DATA_WIDTH-1:0]          rd_data,
  output logic                               rd_burst_req,
  output logic                               wr_burst_req,
  output logic [LEN_WIDTH-1:0]               rd_burst_len,
  output logic [LEN_WIDTH-1:0]               wr_burst_len,
  output logic [DDR_ADDR_WIDTH-1:0]          rd_burst_addr,
  output logic [DDR_ADDR_WIDTH-1:0]          wr_burst_addr,
  output logic [DDR_DATA_WIDTH-1:0]          wr_burst_data,
  input  logic [DDR_DATA_WIDTH-1:0]          rd_burst_data,
  input  logic                               rd_burst_data_valid,
  input  logic                               wr_burst_data_req,
  input  logic                               rd_burst_finish,
  input  logic                               wr_burst_finish,
  input  logic                               init_calib_complete,
  output logic                               busy,
  output logic                               len_err
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  arb_state_t                state, state_nx;
  logic [NUM_CH-1:0]         owner, owner_nx;
  logic [PTR_W-1:0]          owner_idx, owner_idx_nx;
  logic [PTR_W-1:0]          ptr, ptr_nx, arb_ptr, win_idx;
  logic [LEN_WIDTH-1:0]      len_q, len_nx, win_len, beat_cnt, cnt_nx, cnt_inc;
  logic [DDR_ADDR_WIDTH-1:0] addr_q, addr_nx, win_addr;
  logic [DDR_DATA_WIDTH-1:0] owner_data;
  logic [NUM_CH-1:0]         req_any, win;
  logic                      err_nx, beat, fin;

  assign req_any = ch_rd_req | ch_wr_req;
  assign arb_ptr = (RR_EN != 0) ? ptr : '0;

  rr_arbiter #(.NUM_CH(NUM_CH), .PTR_W(PTR_W)) u_rr (
    .req   (req_any),
    .ptr   (arb_ptr),
    .grant (win)
  );

  assign win_idx    = PTR_W'(onehot_index(64'(win)));
  assign win_len    = LEN_WIDTH'(unpack_field(VEC_MAX'(ch_len), int'(win_idx), LEN_WIDTH));
  assign win_addr   = DDR_ADDR_WIDTH'(unpack_field(VEC_MAX'(ch_addr), int'(win_idx),
                                                   DDR_ADDR_WIDTH));
  assign owner_data = DDR_DATA_WIDTH'(unpack_field(VEC_MAX'(ch_wr_data), int'(owner_idx),
                                                   DDR_DATA_WIDTH));

  // Only the open burst's direction counts beats or accepts a finish.
  assign beat    = (state == RD && rd_burst_data_valid) || (state == WR && wr_burst_data_req);
  assign fin     = (state == RD && rd_burst_finish) || (state == WR && wr_burst_finish);
  assign cnt_inc = beat_cnt + LEN_WIDTH'(beat);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= '0;
      owner_idx <= '0;
      ptr       <= '0;
      len_q     <= '0;
      addr_q    <= '0;
      beat_cnt  <= '0;
      len_err   <= 1'b0;
    end else begin
      state     <= state_nx;
      owner     <= owner_nx;
      owner_idx <= owner_idx_nx;
      ptr       <= ptr_nx;
      len_q     <= len_nx;
      addr_q    <= addr_nx;
      beat_cnt  <= cnt_nx;
      len_err   <= err_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    owner_nx     = owner;
    owner_idx_nx = owner_idx;
    ptr_nx       = ptr;
    len_nx       = len_q;
    addr_nx      = addr_q;
    cnt_nx       = beat_cnt;
    err_nx       = len_err;
    case (state)
      IDLE: begin
        if (init_calib_complete && (|req_any)) begin
          owner_nx     = win;
          owner_idx_nx = win_idx;
          len_nx       = win_len;
          addr_nx      = win_addr;
          cnt_nx       = '0;
          if (win_len == '0)            state_nx = DONE;
          else if (|(ch_rd_req & win))  state_nx = RD;
          else                          state_nx = WR;
        end
      end
      RD, WR: begin
        cnt_nx = cnt_inc;
        if (fin) begin
          state_nx = DONE;
          if (cnt_inc != len_q) err_nx = 1'b1;
        end
      end
      DONE: begin
        state_nx = IDLE;
        if (RR_EN != 0)
          ptr_nx = (owner_idx == PTR_W'(NUM_CH - 1)) ? '0 : owner_idx + PTR_W'(1);
      end
      default: state_nx = IDLE;
    endcase
  end

  assign ch_grant       = (state != IDLE) ? owner : '0;
  assign ch_done        = (state == DONE) ? owner : '0;
  assign busy           = (state == RD) || (state == WR);
  assign ch_rd_valid    = {NUM_CH{rd_burst_data_valid}} & ch_grant;
  assign ch_wr_data_req = {NUM_CH{wr_burst_data_req}} & ch_grant;
  assign rd_data        = rd_burst_data;
  assign rd_burst_req   = (state == RD);
  assign wr_burst_req   = (state == WR);
  assign rd_burst_len   = (state == RD) ? len_q : '0;
  assign wr_burst_len   = (state == WR) ? len_q : '0;
  assign rd_burst_addr  = (state == RD) ? addr_q : '0;
  assign wr_burst_addr  = (state == WR) ? addr_q : '0;
  assign wr_burst_data  = (state != IDLE) ? owner_data : '0;

endmodule
